// File: rtl/linebuf_pkg.sv
// Shared constants and helpers for the KxK line-buffer window generator.
package linebuf_pkg;

  localparam int EDGE_VALID_ONLY = 0;
  localparam int EDGE_ZERO_FILL  = 1;

  // Flat tap index of (lane i, row ky, col kx) inside the P*K*K window vector.
  function automatic int idx(input int i, input int ky, input int kx, input int k);
    return (i * k + ky) * k + kx;
  endfunction

endpackage

// File: rtl/linebuf_row_ram.sv
// One buffered image row: WIDTH x BITW storage, P-wide read and P-wide write
// at the same column. The read is combinational so the window sees the value
// stored before this beat's write lands.
module linebuf_row_ram #(
  parameter int WIDTH = 256,
  parameter int BITW  = 8,
  parameter int P     = 4,
  parameter int CW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic            clk,
  input  logic [CW-1:0]   col,
  input  logic            we,
  input  logic [P*BITW-1:0] wdata,
  output logic [P*BITW-1:0] rdata
);

  logic [BITW-1:0] mem [WIDTH];

  // Read the P pixels of the current block.
  always_comb begin
    rdata = '0;
    for (int l = 0; l < P; l++) begin
      rdata[l*BITW +: BITW] = mem[col + CW'(l)];
    end
  end

  // Write the P pixels of the current block; contents are never cleared.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int l = 0; l < P; l++) begin
        mem[col + CW'(l)] <= wdata[l*BITW +: BITW];
      end
    end
  end

endmodule

// File: rtl/linebuf_kxk_win_stream.sv
// P-lane KxK window generator over a raster pixel stream. Keeps K-1 rows in
// line buffers plus a K x (K-1) carrier of the previous block's rightmost
// columns, and emits one registered window per lane per accepted beat.
// Handshake: a beat moves when valid & ready are both high at a clock edge;
// in_ready = !out_valid | out_ready, and out_* hold while out_valid & !out_ready.
module linebuf_kxk_win_stream
  import linebuf_pkg::*;
#(
  parameter int WIDTH     = 256,
  parameter int HEIGHT    = 256,
  parameter int BITW      = 8,
  parameter int P         = 4,
  parameter int K         = 3,
  parameter int EDGE_MODE = EDGE_VALID_ONLY
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_sof,
  input  logic [P*BITW-1:0]     in_pix_vec,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [P*K*K*BITW-1:0] out_win_vec,
  output logic [P-1:0]          out_lane_valid,
  output logic                  out_eol,
  output logic                  out_eof
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int VW = P * K * K * BITW;

  if (WIDTH % P != 0) begin : g_bad_width
    $error("WIDTH must be a multiple of P");
  end
  if (K < 3 || K > 7 || (K % 2) == 0) begin : g_bad_k
    $error("K must be odd and within 3..7");
  end

  logic [CW-1:0]       col;
  logic [RW-1:0]       row;
  logic [BITW-1:0]     car     [K][K-1];
  logic [BITW-1:0]     car_nxt [K][K-1];
  logic [BITW-1:0]     ext     [K][K-1+P];
  logic [P*BITW-1:0]   lb_rd   [K-1];
  logic [P*BITW-1:0]   row_src [K];
  logic                accept;
  logic [CW-1:0]       eff_col;
  logic [RW-1:0]       eff_row;
  logic                last_col;
  logic                last_row;
  logic [VW-1:0]       win;
  logic [P-1:0]        lane_v;

  assign in_ready = !out_valid | out_ready;
  assign accept   = in_valid & in_ready;

  // A sof beat is placed at the frame origin regardless of the counters.
  assign eff_col  = in_sof ? '0 : col;
  assign eff_row  = in_sof ? '0 : row;
  assign last_col = (eff_col == CW'(WIDTH - P));
  assign last_row = (eff_row == RW'(HEIGHT - 1));

  // Line buffer chain: lb[0] takes the incoming row, lb[j] takes lb[j-1].
  for (genvar j = 0; j < K - 1; j++) begin : g_lb
    logic [P*BITW-1:0] wd;
    if (j == 0) begin : g_head
      assign wd = in_pix_vec;
    end else begin : g_tail
      assign wd = lb_rd[j-1];
    end
    linebuf_row_ram #(
      .WIDTH (WIDTH),
      .BITW  (BITW),
      .P     (P),
      .CW    (CW)
    ) u_ram (
      .clk   (clk),
      .col   (eff_col),
      .we    (accept),
      .wdata (wd),
      .rdata (lb_rd[j])
    );
  end

  // Window row ky: ky = K-1 is the live row, lower ky come from older buffers.
  for (genvar ky = 0; ky < K; ky++) begin : g_src
    if (ky == K - 1) begin : g_live
      assign row_src[ky] = in_pix_vec;
    end else begin : g_buf
      assign row_src[ky] = lb_rd[K-2-ky];
    end
  end

  // Assemble carrier+block per row, cut windows, apply edge policy, and
  // form the next carrier from the rightmost K-1 columns.
  always_comb begin
    int r0;
    int c0;
    int tr;
    int tc;
    win    = '0;
    lane_v = '0;
    r0     = int'(eff_row);
    c0     = int'(eff_col);
    for (int ky = 0; ky < K; ky++) begin
      for (int c = 0; c < K - 1; c++) begin
        ext[ky][c] = in_sof ? '0 : car[ky][c];
      end
      for (int l = 0; l < P; l++) begin
        ext[ky][K-1+l] = row_src[ky][l*BITW +: BITW];
      end
    end
    for (int i = 0; i < P; i++) begin
      for (int ky = 0; ky < K; ky++) begin
        for (int kx = 0; kx < K; kx++) begin
          tr = r0 - (K - 1) + ky;
          tc = c0 + i - (K - 1) + kx;
          if (EDGE_MODE == EDGE_ZERO_FILL && (tr < 0 || tc < 0)) begin
            win[idx(i, ky, kx, K)*BITW +: BITW] = '0;
          end else begin
            win[idx(i, ky, kx, K)*BITW +: BITW] = ext[ky][i+kx];
          end
        end
      end
      if (EDGE_MODE == EDGE_ZERO_FILL) begin
        lane_v[i] = 1'b1;
      end else begin
        lane_v[i] = (r0 >= K - 1) && (c0 + i >= K - 1);
      end
    end
    for (int ky = 0; ky < K; ky++) begin
      for (int c = 0; c < K - 1; c++) begin
        car_nxt[ky][c] = ext[ky][P+c];
      end
    end
  end

  // Raster position and carrier state advance once per accepted beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col <= '0;
      row <= '0;
      for (int ky = 0; ky < K; ky++) begin
        for (int c = 0; c < K - 1; c++) begin
          car[ky][c] <= '0;
        end
      end
    end else if (accept) begin
      if (last_col) begin
        col <= '0;
        row <= last_row ? '0 : eff_row + RW'(1);
        for (int ky = 0; ky < K; ky++) begin
          for (int c = 0; c < K - 1; c++) begin
            car[ky][c] <= '0;
          end
        end
      end else begin
        col <= eff_col + CW'(P);
        row <= eff_row;
        for (int ky = 0; ky < K; ky++) begin
          for (int c = 0; c < K - 1; c++) begin
            car[ky][c] <= car_nxt[ky][c];
          end
        end
      end
    end
  end

  // Single output register stage with hold under backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid      <= 1'b0;
      out_win_vec    <= '0;
      out_lane_valid <= '0;
      out_eol        <= 1'b0;
      out_eof        <= 1'b0;
    end else if (accept) begin
      out_valid      <= 1'b1;
      out_win_vec    <= win;
      out_lane_valid <= lane_v;
      out_eol        <= last_col;
      out_eof        <= last_col & last_row;
    end else if (out_ready) begin
      out_valid      <= 1'b0;
      out_lane_valid <= '0;
      out_eol        <= 1'b0;
      out_eof        <= 1'b0;
    end
  end

endmodule

// File: tb/tb_linebuf_kxk_win_stream.sv
// Bench for linebuf_kxk_win_stream: two K=3/P=4 instances (valid-only and
// zero-fill) sharing one stream, and one K=5/P=2 valid-only instance.
module tb_linebuf_kxk_win_stream;

  localparam int BITW = 8;
  localparam int W    = 8;
  localparam int KA   = 3;
  localparam int PA   = 4;
  localparam int HA   = 4;
  localparam int KC   = 5;
  localparam int PC   = 2;
  localparam int HC   = 6;
  localparam int VA   = PA * KA * KA * BITW;
  localparam int VC   = PC * KC * KC * BITW;
  localparam int VMAX = VC;

  typedef struct {
    logic [VMAX-1:0] win;
    logic [3:0]      lv0;
    logic            eol;
    logic            eof;
  } exp_t;

  typedef struct {
    int         row;
    int         col;
    logic [3:0] lv_a;
    logic       eol;
    logic       eof;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic              ab_in_valid, ab_in_sof, ab_out_ready;
  logic [PA*BITW-1:0] ab_pix;
  logic              a_in_ready, a_out_valid, a_eol, a_eof;
  logic [VA-1:0]     a_win;
  logic [PA-1:0]     a_lv;
  logic              b_in_ready, b_out_valid, b_eol, b_eof;
  logic [VA-1:0]     b_win;
  logic [PA-1:0]     b_lv;
  logic              c_in_valid, c_in_sof, c_out_ready;
  logic [PC*BITW-1:0] c_pix;
  logic              c_in_ready, c_out_valid, c_eol, c_eof;
  logic [VC-1:0]     c_win;
  logic [PC-1:0]     c_lv;

  linebuf_kxk_win_stream #(.WIDTH(W), .HEIGHT(HA), .BITW(BITW), .P(PA), .K(KA), .EDGE_MODE(0)) u_a (
    .clk(clk), .rst(rst), .in_valid(ab_in_valid), .in_ready(a_in_ready), .in_sof(ab_in_sof),
    .in_pix_vec(ab_pix), .out_valid(a_out_valid), .out_ready(ab_out_ready), .out_win_vec(a_win),
    .out_lane_valid(a_lv), .out_eol(a_eol), .out_eof(a_eof));

  linebuf_kxk_win_stream #(.WIDTH(W), .HEIGHT(HA), .BITW(BITW), .P(PA), .K(KA), .EDGE_MODE(1)) u_b (
    .clk(clk), .rst(rst), .in_valid(ab_in_valid), .in_ready(b_in_ready), .in_sof(ab_in_sof),
    .in_pix_vec(ab_pix), .out_valid(b_out_valid), .out_ready(ab_out_ready), .out_win_vec(b_win),
    .out_lane_valid(b_lv), .out_eol(b_eol), .out_eof(b_eof));

  linebuf_kxk_win_stream #(.WIDTH(W), .HEIGHT(HC), .BITW(BITW), .P(PC), .K(KC), .EDGE_MODE(0)) u_c (
    .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready), .in_sof(c_in_sof),
    .in_pix_vec(c_pix), .out_valid(c_out_valid), .out_ready(c_out_ready), .out_win_vec(c_win),
    .out_lane_valid(c_lv), .out_eol(c_eol), .out_eof(c_eof));

  // ---------------- scoreboard state ----------------
  int   checks   = 0;
  int   failures = 0;
  int   img [2][8][8];
  int   m_row [2];
  int   m_col [2];
  exp_t exp_q_ab [$];
  exp_t exp_q_c  [$];
  vec_t tbl [8];
  logic [VA-1:0] hold_win;
  logic [PA-1:0] hold_lv;
  logic          hold_eol;

  task automatic cmp(input string name, input logic [VMAX-1:0] act, input logic [VMAX-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: frame image as written so far; a tap is the image pixel at
  // (row-K+1+ky, col+i-K+1+kx), zero when that position is above/left of it.
  task automatic model_accept(input int g, input int k, input int p, input int h,
                              input logic sof, input logic [31:0] pix, output exp_t e);
    int r;
    int c;
    e.win = '0;
    e.lv0 = '0;
    if (sof) begin
      m_row[g] = 0;
      m_col[g] = 0;
    end
    for (int l = 0; l < p; l++) img[g][m_row[g]][m_col[g]+l] = int'(pix[l*BITW +: BITW]);
    for (int i = 0; i < p; i++) begin
      for (int ky = 0; ky < k; ky++) begin
        for (int kx = 0; kx < k; kx++) begin
          r = m_row[g] - (k - 1) + ky;
          c = m_col[g] + i - (k - 1) + kx;
          if (r >= 0 && c >= 0) e.win[((i*k+ky)*k+kx)*BITW +: BITW] = 8'(img[g][r][c]);
        end
      end
      e.lv0[i] = (m_row[g] >= k - 1) && (m_col[g] + i >= k - 1);
    end
    e.eol = (m_col[g] == W - p);
    e.eof = e.eol && (m_row[g] == h - 1);
    if (e.eol) begin
      m_col[g] = 0;
      m_row[g] = (m_row[g] == h - 1) ? 0 : m_row[g] + 1;
    end else begin
      m_col[g] = m_col[g] + p;
    end
  endtask

  function automatic logic [VMAX-1:0] mask_win(input logic [VMAX-1:0] v, input logic [3:0] lv,
                                               input int k, input int p);
    logic [VMAX-1:0] r;
    r = v;
    for (int i = 0; i < p; i++)
      if (!lv[i])
        for (int t = 0; t < k * k; t++) r[(i*k*k+t)*BITW +: BITW] = '0;
    return r;
  endfunction

  function automatic logic [31:0] pat(input int r, input int c, input int p);
    logic [31:0] v;
    v = '0;
    for (int l = 0; l < p; l++) v[l*BITW +: BITW] = 8'(16 * r + c + l);
    return v;
  endfunction

  // ---------------- monitors (sample on falling edge) ----------------
  always @(negedge clk) begin : mon_ab
    exp_t e;
    if (!rst) begin
      cmp("a_out_valid", VMAX'(a_out_valid), VMAX'(exp_q_ab.size() != 0));
      cmp("b_out_valid", VMAX'(b_out_valid), VMAX'(exp_q_ab.size() != 0));
      cmp("a_in_ready", VMAX'(a_in_ready), VMAX'((exp_q_ab.size() == 0) || ab_out_ready));
      cmp("b_in_ready", VMAX'(b_in_ready), VMAX'((exp_q_ab.size() == 0) || ab_out_ready));
      if (a_out_valid && ab_out_ready && exp_q_ab.size() != 0) begin
        e = exp_q_ab.pop_front();
        cmp("a_lane_valid", VMAX'(a_lv), VMAX'(e.lv0));
        cmp("a_eol", VMAX'(a_eol), VMAX'(e.eol));
        cmp("a_eof", VMAX'(a_eof), VMAX'(e.eof));
        cmp("a_win", mask_win(VMAX'(a_win), e.lv0, KA, PA), mask_win(e.win, e.lv0, KA, PA));
        cmp("b_lane_valid", VMAX'(b_lv), VMAX'(4'b1111));
        cmp("b_eol", VMAX'(b_eol), VMAX'(e.eol));
        cmp("b_eof", VMAX'(b_eof), VMAX'(e.eof));
        cmp("b_win", VMAX'(b_win), e.win);
      end
      if (ab_in_valid && a_in_ready) begin
        model_accept(0, KA, PA, HA, ab_in_sof, 32'(ab_pix), e);
        exp_q_ab.push_back(e);
      end
    end
  end

  always @(negedge clk) begin : mon_c
    exp_t e;
    if (!rst) begin
      cmp("c_out_valid", VMAX'(c_out_valid), VMAX'(exp_q_c.size() != 0));
      cmp("c_in_ready", VMAX'(c_in_ready), VMAX'((exp_q_c.size() == 0) || c_out_ready));
      if (c_out_valid && c_out_ready && exp_q_c.size() != 0) begin
        e = exp_q_c.pop_front();
        cmp("c_lane_valid", VMAX'(c_lv), VMAX'(e.lv0[PC-1:0]));
        cmp("c_eol", VMAX'(c_eol), VMAX'(e.eol));
        cmp("c_eof", VMAX'(c_eof), VMAX'(e.eof));
        cmp("c_win", mask_win(VMAX'(c_win), e.lv0, KC, PC), mask_win(e.win, e.lv0, KC, PC));
      end
      if (c_in_valid && c_in_ready) begin
        model_accept(1, KC, PC, HC, c_in_sof, 32'(c_pix), e);
        exp_q_c.push_back(e);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_ab(input logic [31:0] pix, input logic sof);
    ab_in_valid = 1'b1;
    ab_pix      = pix;
    ab_in_sof   = sof;
  endtask

  task automatic drive_c(input logic [31:0] pix, input logic sof);
    c_in_valid = 1'b1;
    c_pix      = pix[15:0];
    c_in_sof   = sof;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    tbl[0] = '{0, 0, 4'b0000, 1'b0, 1'b0};
    tbl[1] = '{0, 4, 4'b0000, 1'b1, 1'b0};
    tbl[2] = '{1, 0, 4'b0000, 1'b0, 1'b0};
    tbl[3] = '{1, 4, 4'b0000, 1'b1, 1'b0};
    tbl[4] = '{2, 0, 4'b1100, 1'b0, 1'b0};
    tbl[5] = '{2, 4, 4'b1111, 1'b1, 1'b0};
    tbl[6] = '{3, 0, 4'b1100, 1'b0, 1'b0};
    tbl[7] = '{3, 4, 4'b1111, 1'b1, 1'b1};

    m_row[0] = 0; m_col[0] = 0; m_row[1] = 0; m_col[1] = 0;
    ab_in_valid = 1'b0; ab_in_sof = 1'b0; ab_pix = '0; ab_out_ready = 1'b1;
    c_in_valid  = 1'b0; c_in_sof  = 1'b0; c_pix  = '0; c_out_ready  = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    cmp("rst_a_out_valid", VMAX'(a_out_valid), '0);
    cmp("rst_a_win", VMAX'(a_win), '0);
    cmp("rst_a_lane_valid", VMAX'(a_lv), '0);
    cmp("rst_a_eol_eof", VMAX'({a_eol, a_eof}), '0);
    cmp("rst_b_out_valid", VMAX'(b_out_valid), '0);
    cmp("rst_b_lane_valid", VMAX'(b_lv), '0);
    cmp("rst_c_out_valid", VMAX'(c_out_valid), '0);
    cmp("rst_c_win", VMAX'(c_win), '0);
    rst = 1'b0;

    // Table: one full K=3 frame, pixel = 16*row+col, no backpressure.
    for (int n = 0; n < 8; n++) begin
      drive_ab(pat(tbl[n].row, tbl[n].col, PA), 1'b0);
      step();
      cmp("tbl_a_lane_valid", VMAX'(a_lv), VMAX'(tbl[n].lv_a));
      cmp("tbl_a_eol", VMAX'(a_eol), VMAX'(tbl[n].eol));
      cmp("tbl_a_eof", VMAX'(a_eof), VMAX'(tbl[n].eof));
      cmp("tbl_b_lane_valid", VMAX'(b_lv), VMAX'(4'b1111));
      cmp("tbl_b_eol", VMAX'(b_eol), VMAX'(tbl[n].eol));
      if (n == 0) begin
        cmp("b_beat0_lane0", VMAX'(b_win[0 +: 72]), '0);
        cmp("b_beat0_lane3_row2", VMAX'(b_win[264 +: 24]), VMAX'(24'h030201));
      end
      if (n == 4) cmp("a_row2_lane2_win", VMAX'(a_win[144 +: 72]), VMAX'(72'h222120121110020100));
    end
    ab_in_valid = 1'b0;
    step();

    // Backpressure: stall 5 cycles mid-row with a beat waiting.
    drive_ab(pat(0, 0, PA), 1'b0); step();
    drive_ab(pat(0, 4, PA), 1'b0); step();
    drive_ab(pat(1, 0, PA), 1'b0); step();
    ab_out_ready = 1'b0;
    drive_ab(pat(1, 4, PA), 1'b0);
    hold_win = a_win; hold_lv = a_lv; hold_eol = a_eol;
    for (int s = 0; s < 5; s++) begin
      step();
      cmp("stall_in_ready", VMAX'(a_in_ready), '0);
      cmp("stall_out_valid", VMAX'(a_out_valid), VMAX'(1'b1));
      cmp("stall_win_hold", VMAX'(a_win), VMAX'(hold_win));
      cmp("stall_lv_eol_hold", VMAX'({a_lv, a_eol}), VMAX'({hold_lv, hold_eol}));
    end
    ab_out_ready = 1'b1;
    step();
    for (int n = 4; n < 8; n++) begin
      drive_ab(pat(tbl[n].row, tbl[n].col, PA), 1'b0);
      step();
    end

    // Mid-frame sof at row 1, col 4.
    drive_ab(pat(0, 0, PA), 1'b0); step();
    drive_ab(pat(0, 4, PA), 1'b0); step();
    drive_ab(pat(1, 0, PA), 1'b0); step();
    drive_ab(pat(1, 4, PA), 1'b1); step();
    cmp("sof_lane_valid", VMAX'(a_lv), '0);
    cmp("sof_eol", VMAX'(a_eol), '0);
    for (int s = 0; s < 3; s++) begin
      drive_ab(32'($urandom()), 1'b0);
      step();
      cmp("sof_no_valid_lane", VMAX'(a_lv), '0);
    end
    drive_ab(32'($urandom()), 1'b0);
    step();
    cmp("sof_row2_lane_valid", VMAX'(a_lv), VMAX'(4'b1100));

    // Asynchronous reset mid-row.
    ab_in_valid = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    cmp("arst_a_out_valid", VMAX'(a_out_valid), '0);
    cmp("arst_b_out_valid", VMAX'(b_out_valid), '0);
    cmp("arst_a_lane_valid", VMAX'(a_lv), '0);
    exp_q_ab.delete();
    exp_q_c.delete();
    m_row[0] = 0; m_col[0] = 0; m_row[1] = 0; m_col[1] = 0;
    step();
    rst = 1'b0;
    drive_ab(32'hA3A2A1A0, 1'b0);
    step();
    cmp("arst_b_lane0_win", VMAX'(b_win[0 +: 72]), VMAX'(72'hA00000000000000000));
    cmp("arst_a_lane_valid_after", VMAX'(a_lv), '0);
    cmp("arst_a_eol_after", VMAX'(a_eol), '0);
    ab_in_valid = 1'b0;

    // K=5, P=2: carrier spans three beats.
    for (int n = 0; n < 24; n++) begin
      drive_c(pat(n / 4, (n % 4) * 2, PC), 1'b0);
      step();
      if (n == 18) begin
        cmp("c_r4c4_lane_valid", VMAX'(c_lv), VMAX'(2'b11));
        cmp("c_r4c4_lane0_row4", VMAX'(c_win[160 +: 40]), VMAX'(40'h4443424140));
        cmp("c_r4c4_lane0_row0", VMAX'(c_win[0 +: 40]), VMAX'(40'h0403020100));
      end
    end
    c_in_valid = 1'b0;

    // Random traffic on both streams against the reference model.
    for (int t = 0; t < 800; t++) begin
      ab_in_valid  = ($urandom_range(0, 3) != 0);
      ab_in_sof    = ($urandom_range(0, 63) == 0);
      ab_pix       = 32'($urandom());
      ab_out_ready = ($urandom_range(0, 3) != 0);
      c_in_valid   = ($urandom_range(0, 3) != 0);
      c_in_sof     = ($urandom_range(0, 63) == 0);
      c_pix        = 16'($urandom());
      c_out_ready  = ($urandom_range(0, 3) != 0);
      step();
    end

    ab_in_valid = 1'b0; ab_in_sof = 1'b0; ab_out_ready = 1'b1;
    c_in_valid  = 1'b0; c_in_sof  = 1'b0; c_out_ready  = 1'b1;
    repeat (3) step();
    cmp("drain_ab_queue", VMAX'(exp_q_ab.size()), '0);
    cmp("drain_c_queue", VMAX'(exp_q_c.size()), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/linebuf_kxk_win_stream.md
Name: linebuf_kxk_win_stream

Overview:
Parametrised successor of the team's 3x3 P-way line-buffer window generator. It accepts P pixels per beat from a raster stream and emits P KxK windows per beat, one per lane, for any odd K. It adds valid/ready backpressure, frame sync (sof), end-of-line/end-of-frame tags and a selectable edge mode. It sits between the pixel unpacker and the P-lane convolution MAC array.

Parameters:
WIDTH, 256, image width in pixels; WIDTH % P == 0 is required (elaboration error otherwise).
HEIGHT, 256, image height in rows; used for eof generation.
BITW, 8, bits per pixel.
P, 4, pixels (lanes) per beat; P >= 1.
K, 3, window size; odd, 3 <= K <= 7.
EDGE_MODE, 0, 0 = valid-only (windows touching outside the image are flagged invalid); 1 = zero-fill (every lane valid, out-of-image taps forced to 0).

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
in_valid  in  1  input beat valid
in_ready  out  1  block can accept a beat
in_sof  in  1  first beat of a frame; qualified by in_valid & in_ready
in_pix_vec  in  P*BITW  lane i at [i*BITW +: BITW]; lane i = column col+i
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts
out_win_vec  out  P*K*K*BITW  tap (lane i, row ky, col kx) at [((i*K+ky)*K+kx)*BITW +: BITW]; ky=0 is oldest row, kx=0 is leftmost column
out_lane_valid  out  P  per-lane window validity
out_eol  out  1  beat holds the last block of a row
out_eof  out  1  beat holds the last block of row HEIGHT-1

Behaviour:
- Reset (async assert, sync deassert): col=0, row=0, all carriers 0, out_valid=0, out_win_vec=0, out_lane_valid=0, out_eol=0, out_eof=0. Line-buffer RAM is not cleared.
- Handshake: accept = in_valid & in_ready. The output is a single register stage, so in_ready = !out_valid | out_ready. Full throughput is one beat per cycle. Latency is 1 cycle from accept to out_valid.
- out_* hold stable while out_valid & !out_ready. out_valid clears on out_ready when there is no new accept.
- Storage: K-1 line buffers lb[0..K-2], each WIDTH x BITW; lb[0] holds row r-1 and lb[K-2] holds row r-K+1.
- Carriers: per row (K rows), the last K-1 columns of the previous beat. On accept, each carrier is replaced by the last K-1 entries of {old carrier, current block}. This holds for any P, including P < K-1.
- Window for lane i covers columns col+i-K+1 .. col+i and rows row-K+1 .. row. Taps are taken from the carriers, then from the block.
- Line update on accept: lb[j][col+l] <= lb[j-1][col+l], and lb[0][col+l] <= pix[l], for l in 0..P-1. Window taps use pre-update values.
- Counters: on accept col += P. When col == WIDTH-P: col <= 0, row++, all carriers <= 0, out_eol=1 on that beat. When row == HEIGHT-1 at that point: out_eof=1 and row <= 0.
- in_sof on an accepted beat: the beat is treated as col=0, row=0. Carriers are zeroed before the beat is used. This resyncs a mid-frame sof; no error flag is raised. Rows above the sof beat are treated as outside the image.
- EDGE_MODE 0: out_lane_valid[i] = (row >= K-1) && (col+i >= K-1).
- EDGE_MODE 1: out_lane_valid = all ones. A tap is forced to 0 when its row index < 0 or its column index < 0. Right and bottom edges are not padded.
- out_lane_valid is meaningful only when out_valid=1 and is 0 while out_valid=0.
- Widths: col is $clog2(WIDTH) bits, row is $clog2(HEIGHT) bits. Comparisons are made in widths sized to avoid wrap.

Decomposition:
- Shared package linebuf_pkg: EDGE_VALID_ONLY=0, EDGE_ZERO_FILL=1, and a tap-index function idx(i,ky,kx,K).
- Sub-module linebuf_row_ram: a WIDTH x BITW array with P-wide read and P-wide write at the same col, one instance per buffered row (K-1 instances).

Test Plan:
- K=3, P=4, WIDTH=8, HEIGHT=4, EDGE_MODE 0, pixel = 16*row+col, out_ready=1 -> first out_lane_valid appears at row 2, col-block 0, value 4'b1100. Lane 2 window: rows 0..2, columns 0..2 = {00,01,02,10,11,12,20,21,22} hex. out_eol on every 2nd beat; out_eof on beat 8.
- Same stimulus with EDGE_MODE 1 -> beat 0 has out_lane_valid=4'b1111. Lane 0 taps are all 0 except tap (2,2)=0x00 pixel. Lane 3 row-2 taps = {01,02,03}.
- K=5, P=2, WIDTH=8 (P < K-1) -> at row 4, col 4, lane 0 window columns 0..4 are correct across a 3-beat carrier span.
- Hold out_ready=0 for 5 cycles mid-row with in_valid=1 -> in_ready=0, out_* stable, no beat lost or duplicated. Output sequence equals the no-stall run.
- Assert in_sof at row 1, col 4 -> that beat behaves as (0,0). In mode 0, no valid lane appears until 2 full rows later.
- Assert rst mid-row for 1 cycle asynchronously -> out_valid=0 immediately. The next accepted beat is treated as (0,0) with zero carriers.
